instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter ARCHITECTURE, default 32, sets the width of address, instruction and PC fields.
REQ-002 Parameter FIFO_DEPTH, default 2, sets the instruction buffer depth; the only supported value is 2.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 pc_i  input  ARCHITECTURE  current address from the program counter.
REQ-006 pc_advance_o  output  1  one-cycle pulse that enables the program counter to step to its next address.
REQ-007 imem_req_o  output  1  instruction memory read request.
REQ-008 imem_addr_o  output  ARCHITECTURE  read address, valid while imem_req_o=1.
REQ-009 imem_ack_i  input  1  memory read complete; imem_data_i valid this cycle.
REQ-010 imem_data_i  input  ARCHITECTURE  read data.
REQ-011 instr_valid_o  output  1  buffer head valid.
REQ-012 instr_ready_i  input  1  downstream accepts the head.
REQ-013 instr_o  output  ARCHITECTURE  head instruction word.
REQ-014 instr_pc_o  output  ARCHITECTURE  address the head instruction was fetched from.
REQ-015 flush_i  input  1  discards buffered and in-flight instructions.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT_ACK and DISCARD; at most one memory request is outstanding.
REQ-017 IDLE: if buffer count < FIFO_DEPTH and flush_i=0, the block SHALL register imem_req_o=1 and imem_addr_o=pc_i, latch pc_i as the fetch PC, and go to WAIT_ACK; otherwise it stays in IDLE with imem_req_o=0.
REQ-018 WAIT_ACK: imem_req_o and imem_addr_o SHALL hold stable until the cycle imem_ack_i=1.
REQ-019 On ack in WAIT_ACK with flush_i=0, the block SHALL push {imem_data_i, fetch PC} into the buffer, drive pc_advance_o=1 for the following cycle only, drop imem_req_o, and go to IDLE.
REQ-020 With zero-wait memory (ack in the first request cycle), throughput SHALL be one instruction every 2 cycles.
REQ-021 The buffer is FIFO ordered. instr_valid_o = (count != 0). instr_o and instr_pc_o SHALL show the head entry. A pop occurs when instr_valid_o and instr_ready_i are both 1.
REQ-022 A push and a pop in the same cycle SHALL leave the count unchanged. Overflow is impossible by REQ-017; a pop with an empty buffer SHALL be ignored.
REQ-023 flush_i=1 at an edge SHALL empty the buffer, giving instr_valid_o=0 the next cycle; any pop in that cycle is void.
REQ-024 flush_i=1 in WAIT_ACK without ack SHALL move the FSM to DISCARD; imem_req_o and imem_addr_o stay held.
REQ-025 DISCARD: on ack, the data SHALL be dropped with no push and no pc_advance_o, and the FSM goes to IDLE. A further flush_i in DISCARD has no added effect.
REQ-026 flush_i coincident with ack in WAIT_ACK SHALL drop the data, give no pc_advance_o, and send the FSM to IDLE.
REQ-027 flush_i in IDLE SHALL suppress request issue that cycle.
REQ-028 pc_advance_o SHALL never pulse more than once per accepted fetch.

Reset
REQ-029 While rst_i=1, independent of clk_i, the block SHALL force: state IDLE, count 0, imem_req_o=0, imem_addr_o=0, pc_advance_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0.
REQ-030 After rst_i deasserts, the first request SHALL be registered on the first rising edge.
REQ-031 Reset during WAIT_ACK or DISCARD SHALL abandon the request; a late ack arriving after reset SHALL be ignored (IDLE ignores ack).

Verification
REQ-032 Zero-wait memory, instr_ready_i=1, pc_i 0->4->8 stepped on each pc_advance_o -> instr_pc_o 0,4,8 with matching data, one every 2 cycles, 3 pc_advance_o pulses.
REQ-033 instr_ready_i=0 -> exactly 2 fetches complete, then imem_req_o stays 0; raise instr_ready_i -> one pop per cycle, and fetching resumes the cycle after the first pop.
REQ-034 Ack delayed 3 cycles, pc_i=0x10 -> imem_req_o=1 and imem_addr_o=0x10 constant for 3 cycles; exactly one push and one pc_advance_o.
REQ-035 flush_i pulse in WAIT_ACK, then ack 2 cycles later with data 0xDEAD -> 0xDEAD never appears on instr_o, no pc_advance_o, next request issued from the current pc_i.
REQ-036 flush_i coincident with ack and a pop, count 1 -> count 0 next cycle, no pc_advance_o, FSM in IDLE.
REQ-037 rst_i asserted mid-WAIT_ACK between clock edges -> all outputs 0 immediately; an ack one cycle after release causes no push.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues one memory read at a time from the program
// counter, buffers returned words with their fetch address in a small FIFO,
// and handles flushes of both buffered and in-flight fetches.
module instruction_fetch #(
  parameter int unsigned ARCHITECTURE = 32,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ARCHITECTURE-1:0] pc_i,
  output logic                    pc_advance_o,
  output logic                    imem_req_o,
  output logic [ARCHITECTURE-1:0] imem_addr_o,
  input  logic                    imem_ack_i,
  input  logic [ARCHITECTURE-1:0] imem_data_i,
  output logic                    instr_valid_o,
  input  logic                    instr_ready_i,
  output logic [ARCHITECTURE-1:0] instr_o,
  output logic [ARCHITECTURE-1:0] instr_pc_o,
  input  logic                    flush_i
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] Depth = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StWaitAck, StDiscard} state_e;

  state_e                  state_q;
  logic [ARCHITECTURE-1:0] fetch_pc_q;
  logic [ARCHITECTURE-1:0] data_q [FIFO_DEPTH];
  logic [ARCHITECTURE-1:0] pc_q   [FIFO_DEPTH];
  logic [PtrW-1:0]         rd_ptr_q;
  logic [PtrW-1:0]         wr_ptr_q;
  logic [CntW-1:0]         count_q;
  logic                    push;
  logic                    pop;

  // A flush voids both the push of a completing fetch and any pop in the same cycle.
  assign push = (state_q == StWaitAck) && imem_ack_i && !flush_i;
  assign pop  = (count_q != '0) && instr_ready_i && !flush_i;

  assign instr_valid_o = (count_q != '0);
  assign instr_o       = data_q[rd_ptr_q];
  assign instr_pc_o    = pc_q[rd_ptr_q];

  // Fetch FSM with registered request, address and PC-advance pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      imem_req_o   <= 1'b0;
      imem_addr_o  <= '0;
      fetch_pc_q   <= '0;
      pc_advance_o <= 1'b0;
    end else begin
      pc_advance_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Late acks are ignored here; only a free slot and no flush start a fetch.
          if ((count_q < Depth) && !flush_i) begin
            imem_req_o  <= 1'b1;
            imem_addr_o <= pc_i;
            fetch_pc_q  <= pc_i;
            state_q     <= StWaitAck;
          end
        end
        StWaitAck: begin
          if (imem_ack_i) begin
            imem_req_o   <= 1'b0;
            pc_advance_o <= !flush_i;
            state_q      <= StIdle;
          end else if (flush_i) begin
            // Request must stay held until memory answers; the answer is dropped.
            state_q <= StDiscard;
          end
        end
        StDiscard: begin
          if (imem_ack_i) begin
            imem_req_o <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Instruction buffer: ring of FIFO_DEPTH entries with pointer pair and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= imem_data_i;
        pc_q[wr_ptr_q]   <= fetch_pc_q;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a behavioural memory (zero-wait or
// manually acked) and a PC that steps by 4 on each pc_advance_o pulse.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i;
  logic        pc_advance_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        flush_i;

  logic        auto_ack;
  logic        man_ack;
  logic        ovr_en;
  logic [31:0] ovr_data;
  logic [31:0] pc_base;
  int          adv_total = 0;
  int          adv_mark;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  // PC model: steps as soon as the advance pulse appears.
  always @(posedge pc_advance_o) adv_total++;
  assign pc_i        = pc_base + 32'(4 * (adv_total - adv_mark));
  assign imem_ack_i  = auto_ack ? imem_req_o : man_ack;
  assign imem_data_i = ovr_en ? ovr_data : (32'hA000_0000 | imem_addr_o);

  instruction_fetch #(.ARCHITECTURE(32), .FIFO_DEPTH(2)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .pc_i          (pc_i),
    .pc_advance_o  (pc_advance_o),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_data_i   (imem_data_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .flush_i       (flush_i)
  );

  task automatic do_reset(input logic [31:0] base);
    rst_i = 1'b1; flush_i = 1'b0; man_ack = 1'b0; auto_ack = 1'b0;
    instr_ready_i = 1'b0; ovr_en = 1'b0; ovr_data = '0;
    pc_base = base; adv_mark = adv_total;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(32'h200);
    auto_ack = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_i = 1'b1;
    #1;
    n_cmp++; if (imem_req_o !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", imem_req_o); end
    n_cmp++; if (imem_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_addr got %h want 0", imem_addr_o); end
    n_cmp++; if (pc_advance_o !== 1'b0) begin n_err++; $display("FAIL rst_adv got %b want 0", pc_advance_o); end
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", instr_valid_o); end
    n_cmp++; if (instr_o !== 32'h0) begin n_err++; $display("FAIL rst_instr got %h want 0", instr_o); end
    n_cmp++; if (instr_pc_o !== 32'h0) begin n_err++; $display("FAIL rst_instr_pc got %h want 0", instr_pc_o); end
    @(negedge clk);
    auto_ack = 1'b0; pc_base = 32'h300; adv_mark = adv_total;
    rst_i = 1'b0;
    #1;
    n_cmp++; if (imem_req_o !== 1'b0) begin n_err++; $display("FAIL rel_req_before_edge got %b want 0", imem_req_o); end
    @(negedge clk);
    n_cmp++; if (imem_req_o !== 1'b1) begin n_err++; $display("FAIL first_req got %b want 1", imem_req_o); end
    n_cmp++; if (imem_addr_o !== 32'h300) begin n_err++; $display("FAIL first_addr got %h want 300", imem_addr_o); end
  endtask

  task automatic test_pipeline();
    logic        e_req [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] e_pc  [6] = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h8, 32'h8};
    int pulses = 0;
    do_reset(32'h0);
    auto_ack = 1'b1; instr_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (pc_advance_o === 1'b1) pulses++;
      n_cmp++; if (imem_req_o !== e_req[i]) begin n_err++; $display("FAIL pipe_req[%0d] got %b want %b", i, imem_req_o, e_req[i]); end
      n_cmp++; if (instr_valid_o !== !e_req[i]) begin n_err++; $display("FAIL pipe_valid[%0d] got %b want %b", i, instr_valid_o, !e_req[i]); end
      if (e_req[i]) begin
        n_cmp++; if (imem_addr_o !== e_pc[i]) begin n_err++; $display("FAIL pipe_addr[%0d] got %h want %h", i, imem_addr_o, e_pc[i]); end
      end else begin
        n_cmp++; if (instr_pc_o !== e_pc[i]) begin n_err++; $display("FAIL pipe_pc[%0d] got %h want %h", i, instr_pc_o, e_pc[i]); end
        n_cmp++; if (instr_o !== (32'hA000_0000 | e_pc[i])) begin n_err++; $display("FAIL pipe_data[%0d] got %h want %h", i, instr_o, 32'hA000_0000 | e_pc[i]); end
      end
    end
    auto_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (pc_advance_o === 1'b1) pulses++;
    end
    n_cmp++; if (pulses !== 3) begin n_err++; $display("FAIL pipe_pulses got %0d want 3", pulses); end
  endtask

  task automatic test_stall();
    int pulses = 0;
    do_reset(32'h100);
    auto_ack = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (pc_advance_o === 1'b1) pulses++;
    end
    n_cmp++; if (pulses !== 2) begin n_err++; $display("FAIL stall_fetches got %0d want 2", pulses); end
    n_cmp++; if (instr_pc_o !== 32'h100) begin n_err++; $display("FAIL stall_head got %h want 100", instr_pc_o); end
    @(negedge clk);
    n_cmp++; if (imem_req_o !== 1'b0) begin n_err++; $display("FAIL stall_req got %b want 0", imem_req_o); end
    n_cmp++; if (instr_valid_o !== 1'b1) begin n_err++; $display("FAIL stall_valid got %b want 1", instr_valid_o); end
    instr_ready_i = 1'b1;
    @(negedge clk);
    n_cmp++; if (instr_pc_o !== 32'h104) begin n_err++; $display("FAIL drain_head got %h want 104", instr_pc_o); end
    n_cmp++; if (instr_valid_o !== 1'b1) begin n_err++; $display("FAIL drain_valid got %b want 1", instr_valid_o); end
    @(negedge clk);
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL drain_empty got %b want 0", instr_valid_o); end
    n_cmp++; if (imem_req_o !== 1'b1) begin n_err++; $display("FAIL resume_req got %b want 1", imem_req_o); end
    n_cmp++; if (imem_addr_o !== 32'h108) begin n_err++; $display("FAIL resume_addr got %h want 108", imem_addr_o); end
    @(negedge clk);
    n_cmp++; if (instr_pc_o !== 32'h108) begin n_err++; $display("FAIL resume_head got %h want 108", instr_pc_o); end
  endtask

  task automatic test_wait_states();
    int pulses = 0;
    do_reset(32'h10);
    instr_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (imem_req_o !== 1'b1) begin n_err++; $display("FAIL ws_req[%0d] got %b want 1", i, imem_req_o); end
      n_cmp++; if (imem_addr_o !== 32'h10) begin n_err++; $display("FAIL ws_addr[%0d] got %h want 10", i, imem_addr_o); end
    end
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    if (pc_advance_o === 1'b1) pulses++;
    n_cmp++; if (instr_valid_o !== 1'b1) begin n_err++; $display("FAIL ws_valid got %b want 1", instr_valid_o); end
    n_cmp++; if (instr_pc_o !== 32'h10) begin n_err++; $display("FAIL ws_pc got %h want 10", instr_pc_o); end
    n_cmp++; if (instr_o !== 32'hA000_0010) begin n_err++; $display("FAIL ws_data got %h want a0000010", instr_o); end
    n_cmp++; if (imem_req_o !== 1'b0) begin n_err++; $display("FAIL ws_req_drop got %b want 0", imem_req_o); end
    repeat (4) begin
      @(negedge clk);
      if (pc_advance_o === 1'b1) pulses++;
    end
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL ws_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_flush_wait();
    int pulses = 0;
    do_reset(32'h20);
    ovr_en = 1'b1; ovr_data = 32'hDEAD; instr_ready_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    pc_base = 32'h40; adv_mark = adv_total;
    n_cmp++; if (imem_addr_o !== 32'h20 || imem_req_o !== 1'b1) begin n_err++; $display("FAIL disc_hold got %b/%h want 1/20", imem_req_o, imem_addr_o); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      man_ack = (i == 0);
      if (pc_advance_o === 1'b1) pulses++;
      n_cmp++; if (instr_valid_o !== 1'b0 || instr_o === 32'hDEAD) begin n_err++; $display("FAIL disc_drop[%0d] got %b/%h want 0/not dead", i, instr_valid_o, instr_o); end
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL disc_pulses got %0d want 0", pulses); end
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin n_err++; $display("FAIL disc_next got %b/%h want 1/40", imem_req_o, imem_addr_o); end
  endtask

  task automatic test_flush_ack_pop();
    do_reset(32'h30);
    @(negedge clk);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    n_cmp++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h30) begin n_err++; $display("FAIL fap_fill got %b/%h want 1/30", instr_valid_o, instr_pc_o); end
    @(negedge clk);
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h34) begin n_err++; $display("FAIL fap_req got %b/%h want 1/34", imem_req_o, imem_addr_o); end
    instr_ready_i = 1'b1; man_ack = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    instr_ready_i = 1'b0; man_ack = 1'b0; flush_i = 1'b0;
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL fap_empty got %b want 0", instr_valid_o); end
    n_cmp++; if (pc_advance_o !== 1'b0) begin n_err++; $display("FAIL fap_adv got %b want 0", pc_advance_o); end
    n_cmp++; if (imem_req_o !== 1'b0) begin n_err++; $display("FAIL fap_idle got %b want 0", imem_req_o); end
    @(negedge clk);
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h34) begin n_err++; $display("FAIL fap_refetch got %b/%h want 1/34", imem_req_o, imem_addr_o); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset(32'h50);
    instr_ready_i = 1'b1;
    @(negedge clk);
    n_cmp++; if (imem_req_o !== 1'b1) begin n_err++; $display("FAIL rmw_req got %b want 1", imem_req_o); end
    #2 rst_i = 1'b1;
    #1;
    n_cmp++; if ({imem_req_o, pc_advance_o, instr_valid_o} !== 3'b000 || imem_addr_o !== 32'h0) begin
      n_err++; $display("FAIL rmw_async got %b%b%b/%h want 000/0", imem_req_o, pc_advance_o, instr_valid_o, imem_addr_o);
    end
    @(negedge clk);
    rst_i = 1'b0; man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    n_cmp++; if (instr_valid_o !== 1'b0 || pc_advance_o !== 1'b0) begin n_err++; $display("FAIL rmw_late_ack got %b/%b want 0/0", instr_valid_o, pc_advance_o); end
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h50) begin n_err++; $display("FAIL rmw_new_req got %b/%h want 1/50", imem_req_o, imem_addr_o); end
    @(negedge clk);
    n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL rmw_no_push got %b want 0", instr_valid_o); end
  endtask

  initial begin
    test_reset();
    test_pipeline();
    test_stall();
    test_wait_states();
    test_flush_wait();
    test_flush_ack_pop();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
